// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmitter. Accepts a parallel word with a valid strobe and sends
//   it on TX_OUT as: start(0), DATA_WIDTH data bits LSB first, optional
//   parity bit, stop(1). Every bit lasts P CLK cycles, where P is the
//   Prescale value latched at accept time (0 is treated as 1).
//
// Ports
//   CLK            in   system clock, posedge
//   RST            in   asynchronous active-high reset
//   P_DATA         in   word to transmit
//   Data_Valid     in   request; sampled only while idle
//   parity_enable  in   1 = append parity bit after the data bits
//   parity_type    in   0 = even (^data), 1 = odd (~^data)
//   Prescale       in   CLK cycles per bit
//   TX_OUT         out  serial line, idles high, driven from a flop
//   busy           out  high while a frame is in progress
//   frame_done     out  one-cycle pulse after the stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_pe;
  logic                  r_parity;
  logic [5:0]            r_presc;
  logic [5:0]            r_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_bit_end;
  logic                  w_parity;
  logic [5:0]            w_presc_eff;

  // Last cycle of the current bit period.
  assign w_bit_end   = (r_cnt == (r_presc - 6'd1));
  assign w_parity    = parity_type ? ~(^P_DATA) : (^P_DATA);
  assign w_presc_eff = (Prescale == 6'd0) ? 6'd1 : Prescale;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_pe      <= 1'b0;
      r_parity  <= 1'b0;
      r_presc   <= 6'd1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (Data_Valid) begin
            // Everything the frame needs is captured here so that later
            // input changes cannot disturb the frame in flight.
            r_shift   <= P_DATA;
            r_pe      <= parity_enable;
            r_parity  <= w_parity;
            r_presc   <= w_presc_eff;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            // Present bit 0 and shift so r_shift[0] is always the next bit.
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              if (r_pe) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Driver issues frames (directed + random) and pushes a frame descriptor
//   into a queue at accept time. A separate monitor detects each start bit,
//   pops the descriptor, expands it into the expected line waveform
//   (start, data LSB first, parity, stop, each P cycles) and compares
//   TX_OUT / busy / frame_done cycle by cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         pt;
    int         p;
  } frame_t;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       parity_enable;
  logic       parity_type;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;
  logic       frame_done;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  bit     mon_active = 0;
  frame_t exp_q[$];
  int     start_cyc[$];

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .P_DATA       (P_DATA),
    .Data_Valid   (Data_Valid),
    .parity_enable(parity_enable),
    .parity_type  (parity_type),
    .Prescale     (Prescale),
    .TX_OUT       (TX_OUT),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    frame_t f;
    bit     bits[$];
    bit     aborted;
    int     bad_tx;
    int     bad_busy;
    int     bad_done;
    forever begin
      @(negedge CLK);
      if (RST) continue;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL stray_frame_done: frame_done=%b required 0 (cycle %0d)", frame_done, cyc);
      end
      if (TX_OUT === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: start bit seen at cycle %0d with no request outstanding", cyc);
          for (int n = 0; n < 2000 && TX_OUT !== 1'b1; n++) @(negedge CLK);
        end else begin
          f = exp_q.pop_front();
          start_cyc.push_back(cyc);
          mon_active = 1;
          aborted    = 0;
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
          if (f.pe) bits.push_back(f.pt ? ~(^f.data) : (^f.data));
          bits.push_back(1'b1);
          for (int b = 0; b < bits.size() && !aborted; b++) begin
            bad_tx = 0; bad_busy = 0; bad_done = 0;
            for (int k = 0; k < f.p; k++) begin
              if (!(b == 0 && k == 0)) @(negedge CLK);
              if (RST) begin
                aborted = 1;
                break;
              end
              if (TX_OUT !== bits[b]) bad_tx++;
              if (busy !== 1'b1) bad_busy++;
              if (frame_done !== 1'b0) bad_done++;
            end
            if (!aborted) begin
              if (bad_tx != 0 || bad_busy != 0 || bad_done != 0) begin
                errors++;
                $display("FAIL frame_bit: data=%02h pe=%0d pt=%0d P=%0d bit#%0d required tx=%0d; got %0d bad tx, %0d bad busy, %0d bad frame_done samples",
                         f.data, f.pe, f.pt, f.p, b, bits[b], bad_tx, bad_busy, bad_done);
              end
            end
          end
          if (!aborted) begin
            @(negedge CLK);
            checks++;
            if (!RST && (frame_done !== 1'b1 || busy !== 1'b0 || TX_OUT !== 1'b1)) begin
              errors++;
              $display("FAIL frame_end: data=%02h got frame_done=%b busy=%b tx=%b required 1 0 1",
                       f.data, frame_done, busy, TX_OUT);
            end else if (!RST) begin
              $display("frame ok: data=%02h pe=%0d pt=%0d P=%0d start_cycle=%0d",
                       f.data, f.pe, f.pt, f.p, start_cyc[start_cyc.size()-1]);
            end
          end
          mon_active = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0 within 3000 cycles", busy);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit pe, input bit pt,
                      input int presc, input bit junk);
    frame_t f;
    wait_idle();
    P_DATA        = d;
    parity_enable = pe;
    parity_type   = pt;
    Prescale      = presc[5:0];
    Data_Valid    = 1'b1;
    @(posedge CLK);
    f.data = d; f.pe = pe; f.pt = pt; f.p = (presc == 0) ? 1 : presc;
    exp_q.push_back(f);
    @(negedge CLK);
    Data_Valid = 1'b0;
    if (junk) begin
      // Shortest frame is 10 cycles, so these cycles are all mid-frame.
      for (int k = 0; k < 4; k++) begin
        P_DATA        = 8'($urandom);
        Prescale      = 6'($urandom);
        parity_enable = 1'($urandom);
        parity_type   = 1'($urandom);
        Data_Valid    = 1'($urandom);
        @(negedge CLK);
      end
      Data_Valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || busy !== 1'b0) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames still expected", exp_q.size());
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin : driver
    int     first_idx;
    int     dn_bad;
    frame_t f;
    RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0;
    parity_enable = 1'b0; parity_type = 1'b0; Prescale = 6'd0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b frame_done=%b required 1 0 0", TX_OUT, busy, frame_done);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // T1 / T2
    send(8'hBB, 1, 1, 32, 0);
    send(8'hBB, 1, 0, 16, 0);
    send(8'hBB, 0, 0, 16, 1);
    send(8'hBB, 0, 0, 8, 1);
    // T7
    send(8'h3C, 1, 0, 0, 0);
    send(8'hC5, 0, 1, 0, 1);
    drain();

    // T4: Data_Valid held high across two frames
    first_idx     = start_cyc.size();
    P_DATA        = 8'h55;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    Prescale      = 6'd8;
    Data_Valid    = 1'b1;
    @(posedge CLK);
    f.data = 8'h55; f.pe = 0; f.pt = 0; f.p = 8;
    exp_q.push_back(f);
    @(negedge CLK);
    P_DATA = 8'hA3;
    wait_idle();
    @(posedge CLK);
    f.data = 8'hA3;
    exp_q.push_back(f);
    @(negedge CLK);
    Data_Valid = 1'b0;
    drain();
    checks++;
    if (start_cyc.size() < first_idx + 2) begin
      errors++;
      $display("FAIL b2b_count: saw %0d start bits required 2", start_cyc.size() - first_idx);
    end else if (start_cyc[first_idx+1] - start_cyc[first_idx] != 81) begin
      errors++;
      $display("FAIL b2b_period: got %0d cycles required 81",
               start_cyc[first_idx+1] - start_cyc[first_idx]);
    end

    // T6: reset during data bit 4 (0xAF has bit 4 = 0, so the line is low)
    send(8'hAF, 0, 0, 4, 0);
    repeat (21) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_tx: tx=%b required 0 during data bit 4", TX_OUT);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b frame_done=%b required 1 0 0", TX_OUT, busy, frame_done);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    dn_bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (frame_done !== 1'b0 || TX_OUT !== 1'b1) dn_bad++;
    end
    checks++;
    if (dn_bad != 0) begin
      errors++;
      $display("FAIL reset_abort: %0d cycles with frame_done/tx activity after abort, required 0", dn_bad);
    end
    send(8'h96, 1, 1, 4, 0);
    drain();

    // Random frames with mid-frame input churn
    for (int i = 0; i < 30; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 10)), 1'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
